// File: rtl/window_max_pool.sv
// Sliding FILTER_SIZE x FILTER_SIZE window with a two-stage max-reduction pipeline.
// A window accepted on a strobe edge yields pool_out / pool_valid two edges later.
module window_max_pool #(
  parameter int FILTER_SIZE = 2,
  parameter int DATA_WIDTH  = 8,
  parameter bit SIGNED      = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clk_en,
  input  logic [FILTER_SIZE*DATA_WIDTH-1:0] col_in,
  input  logic                              win_valid_in,
  output logic [DATA_WIDTH-1:0]             pool_out,
  output logic                              pool_valid
);

  function automatic logic f_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  logic [DATA_WIDTH-1:0] r_win     [FILTER_SIZE][FILTER_SIZE];
  logic [DATA_WIDTH-1:0] r_row_max [FILTER_SIZE];
  logic [DATA_WIDTH-1:0] w_row_max [FILTER_SIZE];
  logic [DATA_WIDTH-1:0] w_win_max;
  logic                  r_v0;
  logic                  r_v1;

  // Column FILTER_SIZE-1 is the newest; the window only moves on a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < FILTER_SIZE; r++)
        for (int c = 0; c < FILTER_SIZE; c++)
          r_win[r][c] <= '0;
    end else if (clk_en) begin
      for (int r = 0; r < FILTER_SIZE; r++) begin
        for (int c = 0; c < FILTER_SIZE-1; c++)
          r_win[r][c] <= r_win[r][c+1];
        r_win[r][FILTER_SIZE-1] <= col_in[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < FILTER_SIZE; r++) begin
      w_row_max[r] = r_win[r][0];
      for (int c = 1; c < FILTER_SIZE; c++)
        if (f_gt(r_win[r][c], w_row_max[r])) w_row_max[r] = r_win[r][c];
    end
  end

  always_comb begin
    w_win_max = r_row_max[0];
    for (int r = 1; r < FILTER_SIZE; r++)
      if (f_gt(r_row_max[r], w_win_max)) w_win_max = r_row_max[r];
  end

  // Pipeline stages run every edge so strobe gaps never stall a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      pool_valid <= 1'b0;
      pool_out   <= '0;
      for (int r = 0; r < FILTER_SIZE; r++)
        r_row_max[r] <= '0;
    end else begin
      r_v0       <= clk_en & win_valid_in;
      r_v1       <= r_v0;
      pool_valid <= r_v1;
      for (int r = 0; r < FILTER_SIZE; r++)
        r_row_max[r] <= w_row_max[r];
      if (r_v1) pool_out <= w_win_max;
    end
  end

endmodule

// File: tb/tb_window_max_pool.sv
// Bench for window_max_pool: directed vector table, hand-written corner sequences
// and randomized stimulus against a column-history reference model.
module tb_window_max_pool;
  localparam int FS = 2;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clk_en;
  logic             win_valid_in;
  logic [FS*DW-1:0] col_in;
  logic [DW-1:0]    out_u, out_s;
  logic             val_u, val_s;

  always #5 clk = ~clk;

  window_max_pool #(.FILTER_SIZE(FS), .DATA_WIDTH(DW), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .col_in(col_in),
    .win_valid_in(win_valid_in), .pool_out(out_u), .pool_valid(val_u));

  window_max_pool #(.FILTER_SIZE(FS), .DATA_WIDTH(DW), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .col_in(col_in),
    .win_valid_in(win_valid_in), .pool_out(out_s), .pool_valid(val_s));

  int total = 0;
  int bad   = 0;

  // Reference model: last FS accepted columns plus a list of results due at a given edge.
  typedef struct {int due; logic [DW-1:0] u; logic [DW-1:0] s;} res_t;
  logic [FS*DW-1:0] m_cols[$];
  res_t             m_pend[$];
  int               cyc = 0;
  logic             m_v;
  logic [DW-1:0]    m_u, m_s;

  typedef struct {logic en; logic wv; logic [FS*DW-1:0] col; logic ev; logic [DW-1:0] eo;} vec_t;
  vec_t tbl[15];

  function automatic logic [FS*DW-1:0] mk(input logic [DW-1:0] r0, input logic [DW-1:0] r1);
    return {r1, r0};
  endfunction

  task automatic model_reset();
    m_cols.delete();
    for (int i = 0; i < FS; i++) m_cols.push_back('0);
    m_pend.delete();
    m_v = 1'b0;
    m_u = '0;
    m_s = '0;
  endtask

  task automatic model_edge(input logic en, input logic wv, input logic [FS*DW-1:0] col);
    res_t             r;
    logic [FS*DW-1:0] c;
    logic [DW-1:0]    p;
    cyc++;
    if (en) begin
      m_cols.push_back(col);
      void'(m_cols.pop_front());
    end
    if (en && wv) begin
      r.due = cyc + 2;
      c     = m_cols[0];
      r.u   = c[DW-1:0];
      r.s   = c[DW-1:0];
      foreach (m_cols[i]) begin
        c = m_cols[i];
        for (int k = 0; k < FS; k++) begin
          p = c[k*DW +: DW];
          if (p > r.u) r.u = p;
          if ($signed(p) > $signed(r.s)) r.s = p;
        end
      end
      m_pend.push_back(r);
    end
    m_v = 1'b0;
    if (m_pend.size() > 0 && m_pend[0].due == cyc) begin
      m_v = 1'b1;
      m_u = m_pend[0].u;
      m_s = m_pend[0].s;
      void'(m_pend.pop_front());
    end
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp4(input string tag, input logic ev, input logic [DW-1:0] eu, input logic [DW-1:0] es);
    chk({tag, "/valid_u"}, {7'b0, val_u}, {7'b0, ev});
    chk({tag, "/out_u"},   out_u, eu);
    chk({tag, "/valid_s"}, {7'b0, val_s}, {7'b0, ev});
    chk({tag, "/out_s"},   out_s, es);
  endtask

  task automatic step(input logic en, input logic wv, input logic [FS*DW-1:0] col);
    clk_en       = en;
    win_valid_in = wv;
    col_in       = col;
    @(posedge clk);
    if (rst_n) model_edge(en, wv, col);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; win_valid_in = 1'b0; col_in = '0;
    model_reset();

    // reset held with random inputs, then released with the strobe idle
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      cmp4("reset_hold", 1'b0, 8'h00, 8'h00);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
      cmp4("reset_rel", 1'b0, 8'h00, 8'h00);
    end

    // basic window, back-to-back accepts, strobe gaps with win_valid_in high while idle
    tbl[0]  = '{1'b1, 1'b0, mk(8'd3, 8'd7), 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b1, mk(8'd9, 8'd1), 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, mk(8'd2, 8'd4), 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b1, mk(8'd5, 8'd0), 1'b1, 8'd9};
    tbl[4]  = '{1'b0, 1'b1, 16'hAAAA,       1'b1, 8'd9};
    tbl[5]  = '{1'b0, 1'b1, 16'hAAAA,       1'b1, 8'd5};
    tbl[6]  = '{1'b0, 1'b1, 16'hAAAA,       1'b0, 8'd5};
    tbl[7]  = '{1'b1, 1'b1, mk(8'd6, 8'd2), 1'b0, 8'd5};
    tbl[8]  = '{1'b0, 1'b1, 16'hAAAA,       1'b0, 8'd5};
    tbl[9]  = '{1'b0, 1'b1, 16'hAAAA,       1'b1, 8'd6};
    tbl[10] = '{1'b0, 1'b1, 16'hAAAA,       1'b0, 8'd6};
    tbl[11] = '{1'b1, 1'b1, mk(8'd1, 8'd8), 1'b0, 8'd6};
    tbl[12] = '{1'b0, 1'b1, 16'hAAAA,       1'b0, 8'd6};
    tbl[13] = '{1'b0, 1'b1, 16'hAAAA,       1'b1, 8'd8};
    tbl[14] = '{1'b0, 1'b0, 16'hAAAA,       1'b0, 8'd8};
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].en, tbl[i].wv, tbl[i].col);
      cmp4($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eo, tbl[i].eo);
    end

    // signedness: same window, different maximum per SIGNED
    step(1'b1, 1'b0, mk(8'h80, 8'h01));
    step(1'b1, 1'b1, mk(8'hFF, 8'h7F));
    step(1'b0, 1'b0, 16'h0000);
    cmp4("sign_e1", 1'b0, 8'd8, 8'd8);
    step(1'b0, 1'b0, 16'h0000);
    cmp4("sign_e2", 1'b1, 8'hFF, 8'h7F);
    step(1'b0, 1'b0, 16'h0000);
    cmp4("sign_hold", 1'b0, 8'hFF, 8'h7F);

    // reset in flight between E0+1 and E0+2
    step(1'b1, 1'b0, mk(8'h11, 8'h22));
    step(1'b1, 1'b1, mk(8'h33, 8'h44));
    step(1'b0, 1'b0, 16'h0000);
    cmp4("rif_e1", 1'b0, 8'hFF, 8'h7F);
    #2 rst_n = 1'b0;
    #1 cmp4("rif_async", 1'b0, 8'h00, 8'h00);
    model_reset();
    @(posedge clk);
    #1 cmp4("rif_e2", 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 16'($urandom));
      cmp4("rif_after", 1'b0, 8'h00, 8'h00);
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 16'($urandom));
      cmp4("rand", m_v, m_u, m_s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
